// File: rtl/sram_master_if.sv
// Command, write-data, read-data and SRAM pin bundle for sram_master.
// master: the sram_master view; slave: the client/SRAM-side view.
interface sram_master_if #(
    parameter int N = 4,
    parameter int M = 16
);
    localparam int AW = $clog2(M);

    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_len;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [N-1:0]  wdata;
    logic          rdata_valid;
    logic          rdata_ready;
    logic [N-1:0]  rdata;
    logic          rdata_last;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_din;
    logic [N-1:0]  mem_dout;

    modport master (
        input  req_valid, req_write, req_addr, req_len,
        input  wdata_valid, wdata, rdata_ready, mem_dout,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last,
        output mem_en, mem_addr, mem_din
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len,
        output wdata_valid, wdata, rdata_ready, mem_dout,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last,
        input  mem_en, mem_addr, mem_din
    );
endinterface

// File: rtl/sram_master.sv
// Burst initiator for a single-port SRAM; writes 1 beat/cycle, reads 1 beat/2 cycles (RESP one edge after READ).
// Backpressure: wdata_valid gaps stall writes, rdata_ready low holds rdata; optional SRAM_MASTER_STATS_EN adds beat_cnt.
module sram_master #(
    parameter int N = 4,
    parameter int M = 16
) (
    input  logic                clk,
    input  logic                reset,
    sram_master_if.master       bus
`ifdef SRAM_MASTER_STATS_EN
    ,
    output logic [15:0]         beat_cnt
`endif
);
    localparam int AW = $clog2(M);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [AW-1:0] beats_left_q, beats_left_d;
    logic [AW-1:0] addr_inc;
    logic          last_beat;
    logic          req_hs, wr_hs, rd_hs;

    // Explicit wrap so non-power-of-two depths never address past M-1.
    assign addr_inc  = (cur_addr_q == AW'(M - 1)) ? '0 : cur_addr_q + AW'(1);
    assign last_beat = (beats_left_q == '0);

    assign bus.req_ready   = (state_q == S_IDLE)  && !reset;
    assign bus.wdata_ready = (state_q == S_WRITE) && !reset;
    assign bus.rdata_valid = (state_q == S_RESP)  && !reset;
    assign bus.rdata_last  = (state_q == S_RESP)  && !reset && last_beat;
    assign bus.rdata       = bus.mem_dout;
    assign bus.mem_en      = bus.wdata_ready && bus.wdata_valid;
    assign bus.mem_din     = bus.mem_en ? bus.wdata : '0;
    assign bus.mem_addr    = cur_addr_q;

    assign req_hs = bus.req_valid   && bus.req_ready;
    assign wr_hs  = bus.wdata_valid && bus.wdata_ready;
    assign rd_hs  = bus.rdata_valid && bus.rdata_ready;

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        case (state_q)
            S_IDLE: begin
                if (req_hs) begin
                    cur_addr_d   = bus.req_addr;
                    beats_left_d = bus.req_len;
                    state_d      = bus.req_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (wr_hs) begin
                    cur_addr_d = addr_inc;
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        beats_left_d = beats_left_q - AW'(1);
                    end
                end
            end
            S_READ: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                // Address is held through RESP so the registered SRAM output stays put.
                if (rd_hs) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        cur_addr_d   = addr_inc;
                        beats_left_d = beats_left_q - AW'(1);
                        state_d      = S_READ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
        end
    end

`ifdef SRAM_MASTER_STATS_EN
    logic [15:0] beat_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q <= '0;
        end else if ((wr_hs || rd_hs) && (beat_cnt_q != 16'hFFFF)) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif
endmodule

// File: tb/tb_sram_master.sv
// Randomized bench for sram_master against a behavioural SRAM image and beat-count model.
module tb_sram_master;
    localparam int N  = 4;
    localparam int M  = 16;
    localparam int AW = $clog2(M);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_master_if #(.N(N), .M(M)) bus();

`ifdef SRAM_MASTER_STATS_EN
    logic [15:0] beat_cnt;
`endif

    sram_master #(.N(N), .M(M)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef SRAM_MASTER_STATS_EN
        ,
        .beat_cnt (beat_cnt)
`endif
    );

    // SRAM responder: en=1 writes, en=0 registers the addressed word onto dout.
    logic [N-1:0] sram [M];
    logic [N-1:0] dout_q;
    always @(posedge clk) begin
        if (bus.mem_en) sram[bus.mem_addr] <= bus.mem_din;
        else            dout_q <= sram[bus.mem_addr];
    end
    assign bus.mem_dout = dout_q;

    logic [N-1:0] ref_mem [M];
    logic [N-1:0] wbuf [M];
    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int addr, input int len, input int gappy);
        int beat = 0;
        int cyc  = 0;
        int a;
        logic wv;
        logic [N-1:0] exp_din;
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr  = AW'(addr); bus.req_len = AW'(len);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL wr_req_ready got %b want 1", bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = AW'($urandom);
        while (beat <= len && cyc < 1000) begin
            a  = (addr + beat) % M;
            wv = (gappy == 0) || ($urandom_range(2, 0) != 0);
            bus.wdata_valid = wv;
            bus.wdata       = wv ? wbuf[AW'(beat)] : N'($urandom);
            exp_din         = wv ? wbuf[AW'(beat)] : '0;
            #1;
            checks++;
            if (bus.wdata_ready !== 1'b1 || bus.mem_en !== wv || bus.mem_addr !== AW'(a) ||
                bus.mem_din !== exp_din || bus.req_ready !== 1'b0 || bus.rdata_valid !== 1'b0) begin
                errors++;
                $display("FAIL wr_beat %0d got rdy=%b en=%b addr=%0d din=%h want rdy=1 en=%b addr=%0d din=%h",
                         beat, bus.wdata_ready, bus.mem_en, bus.mem_addr, bus.mem_din, wv, a, exp_din);
            end
            tick();
            if (wv) begin
                ref_mem[AW'(a)] = wbuf[AW'(beat)];
                beat++;
                exp_cnt++;
            end
            cyc++;
        end
        bus.wdata_valid = 1'b0;
        if (cyc >= 1000) begin
            checks++; errors++; $display("FAIL wr_timeout got beats=%0d want %0d", beat, len + 1);
        end
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.wdata_ready !== 1'b0 || bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL wr_done got req_rdy=%b wrdy=%b en=%b want 1 0 0", bus.req_ready, bus.wdata_ready, bus.mem_en);
        end
    endtask

    task automatic do_read(input int addr, input int len, input int smin, input int smax);
        int a;
        int stall;
        bus.req_valid = 1'b1; bus.req_write = 1'b0;
        bus.req_addr  = AW'(addr); bus.req_len = AW'(len);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rd_req_ready got %b want 1", bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            a = (addr + b) % M;
            bus.rdata_ready = 1'($urandom_range(1, 0));
            #1;
            checks++;
            if (bus.rdata_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_addr !== AW'(a)) begin
                errors++;
                $display("FAIL rd_fetch %0d got vld=%b en=%b addr=%0d want 0 0 %0d",
                         b, bus.rdata_valid, bus.mem_en, bus.mem_addr, a);
            end
            tick();
            stall = $urandom_range(smax, smin);
            for (int s = 0; s <= stall; s++) begin
                bus.rdata_ready = (s == stall);
                #1;
                checks++;
                if (bus.rdata_valid !== 1'b1 || bus.rdata !== ref_mem[AW'(a)] ||
                    bus.rdata_last !== (b == len) || bus.mem_en !== 1'b0 || bus.req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_beat %0d got vld=%b data=%h last=%b en=%b want 1 %h %b 0",
                             b, bus.rdata_valid, bus.rdata, bus.rdata_last, bus.mem_en, ref_mem[AW'(a)], b == len);
                end
                tick();
            end
            exp_cnt++;
        end
        bus.rdata_ready = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rdata_valid !== 1'b0) begin
            errors++; $display("FAIL rd_done got req_rdy=%b vld=%b want 1 0", bus.req_ready, bus.rdata_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = '0; bus.req_len = '0;
        bus.wdata_valid = 1'b1; bus.wdata = '1; bus.rdata_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.req_ready !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_addr !== '0 || bus.wdata_ready !== 1'b0 ||
            bus.rdata_valid !== 1'b0 || bus.rdata_last !== 1'b0 || bus.mem_din !== '0) begin
            errors++;
            $display("FAIL reset_outs got req_rdy=%b en=%b addr=%0d wrdy=%b vld=%b last=%b din=%h want all 0",
                     bus.req_ready, bus.mem_en, bus.mem_addr, bus.wdata_ready, bus.rdata_valid, bus.rdata_last, bus.mem_din);
        end
`ifdef SRAM_MASTER_STATS_EN
        checks++;
        if (beat_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", beat_cnt); end
`endif
        bus.req_valid = 1'b0; bus.wdata_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_release got req_rdy=%b want 1", bus.req_ready); end
        tick();
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 4; i++) wbuf[i] = N'(i + 1);
        do_write(3, 3, 0);
        do_read(3, 3, 0, 0);
`ifdef SRAM_MASTER_STATS_EN
        checks++;
        if (beat_cnt !== 16'd8) begin errors++; $display("FAIL stats_cnt got %0d want 8", beat_cnt); end
`endif
    endtask

    task automatic test_wrap();
        wbuf[0] = 4'hA; wbuf[1] = 4'hB; wbuf[2] = 4'hC; wbuf[3] = 4'hD;
        do_write(14, 3, 0);
        checks++;
        if (sram[14] !== 4'hA || sram[15] !== 4'hB || sram[0] !== 4'hC || sram[1] !== 4'hD) begin
            errors++;
            $display("FAIL wrap_mem got %h %h %h %h want a b c d", sram[14], sram[15], sram[0], sram[1]);
        end
        do_read(14, 3, 0, 1);
    endtask

    task automatic test_backpressure();
        do_read(0, 1, 5, 5);
        for (int i = 0; i < 4; i++) wbuf[i] = N'($urandom);
        do_write(6, 3, 1);
        do_read(6, 3, 0, 3);
    endtask

    task automatic test_reset_mid_write();
        wbuf[0] = 4'h5; wbuf[1] = 4'h6; wbuf[2] = 4'h7; wbuf[3] = 4'h8;
        do_write(8, 3, 0);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = AW'(8); bus.req_len = AW'(3);
        tick();
        bus.req_valid = 1'b0;
        bus.wdata_valid = 1'b1;
        bus.wdata = 4'h9; tick();
        bus.wdata = 4'hE; tick();
        bus.wdata = 4'h1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_en !== 1'b0 || bus.req_ready !== 1'b0 || bus.wdata_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_reset got en=%b req_rdy=%b wrdy=%b want 0 0 0", bus.mem_en, bus.req_ready, bus.wdata_ready);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.wdata_ready !== 1'b0 || bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_release got req_rdy=%b wrdy=%b en=%b want 1 0 0", bus.req_ready, bus.wdata_ready, bus.mem_en);
        end
        tick();
        bus.wdata_valid = 1'b0;
        ref_mem[8] = 4'h9; ref_mem[9] = 4'hE;
        exp_cnt = 0;
        checks++;
        if (sram[8] !== 4'h9 || sram[9] !== 4'hE || sram[10] !== 4'h7 || sram[11] !== 4'h8) begin
            errors++;
            $display("FAIL abort_mem got %h %h %h %h want 9 e 7 8", sram[8], sram[9], sram[10], sram[11]);
        end
`ifdef SRAM_MASTER_STATS_EN
        checks++;
        if (beat_cnt !== 16'd0) begin errors++; $display("FAIL abort_cnt got %0d want 0", beat_cnt); end
`endif
    endtask

    task automatic test_single_and_full();
        do_read(8, 0, 0, 2);
        for (int i = 0; i < M; i++) wbuf[i] = N'($urandom);
        do_write(5, 15, 0);
        for (int i = 0; i < M; i++) begin
            checks++;
            if (sram[i] !== wbuf[AW'((i + M - 5) % M)]) begin
                errors++;
                $display("FAIL full_mem[%0d] got %h want %h", i, sram[i], wbuf[AW'((i + M - 5) % M)]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int addr;
        int len;
        for (int it = 0; it < 30; it++) begin
            addr = $urandom_range(M - 1, 0);
            len  = $urandom_range(M - 1, 0);
            if ($urandom_range(1, 0) == 1) begin
                for (int i = 0; i < M; i++) wbuf[i] = N'($urandom);
                do_write(addr, len, $urandom_range(1, 0));
            end else begin
                do_read(addr, len, 0, 3);
            end
        end
`ifdef SRAM_MASTER_STATS_EN
        checks++;
        if (beat_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL final_cnt got %0d want %0d", beat_cnt, exp_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_backpressure();
        test_reset_mid_write();
        test_single_and_full();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
